// File: rtl/uart_xfer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// md5_xfer_pkg
// Shared definitions for the uart/MD5 transfer sequencer: command op codes,
// completion status codes, FSM state encoding and the default block sizes.
// No ports (package).
// ---------------------------------------------------------------------------
package md5_xfer_pkg;

  localparam int MSG_BYTES_DEF    = 64;  // 512-bit message block
  localparam int DIGEST_BYTES_DEF = 16;  // 128-bit digest

  typedef enum logic [1:0] {
    OP_RX         = 2'd0,
    OP_TX         = 2'd1,
    OP_RX_HASH_TX = 2'd2,
    OP_HASH       = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_ERR_SLOT    = 2'd1,
    ST_ERR_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    U_WAIT_IDLE = 3'd1,
    U_START     = 3'd2,
    U_WAIT_BUSY = 3'd3,
    U_WAIT_DONE = 3'd4,
    C_START     = 3'd5,
    C_WAIT      = 3'd6,
    DONE        = 3'd7
  } state_e;

  // States in which the sequencer is stalled on an external handshake.
  function automatic logic is_wait_state(state_e s);
    return (s == U_WAIT_IDLE) || (s == U_WAIT_BUSY) ||
           (s == U_WAIT_DONE) || (s == C_WAIT);
  endfunction

endpackage

// File: rtl/uart_xfer_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// xfer_watchdog
// Per-state stall watchdog for uart_xfer_sequencer. Only compiled when the
// XFER_TIMEOUT_EN macro is defined; the default build has no watchdog.
//
// Down-counter reloaded on clear_i (first cycle of a state). While en_i is
// high it decrements once per cycle; expired_o is raised in the cycle where
// the state has been active for LIMIT-1 cycles (count reaches zero).
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   clear_i    first cycle of a newly entered state
//   en_i       count enable (FSM is in a wait state)
//   expired_o  terminal count reached this cycle
// ---------------------------------------------------------------------------
`ifdef XFER_TIMEOUT_EN
module xfer_watchdog #(
  parameter int LIMIT = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_cur;
  logic [CW-1:0] cnt_d;

  // The clear cycle already counts as elapsed cycle 0 of the new state, so
  // the reload value is used directly rather than waiting a cycle for it.
  assign cnt_cur   = clear_i ? CW'(LIMIT - 1) : cnt_q;
  assign expired_o = en_i && (cnt_cur == '0);
  assign cnt_d     = (en_i && (cnt_cur != '0)) ? (cnt_cur - CW'(1)) : cnt_cur;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CW'(LIMIT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/uart_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// uart_xfer_sequencer
// Command-driven sequencer between host control, uart_manager and the MD5
// core. Each of NUM_SLOTS RAM slots holds a message block at
// slot*SLOT_STRIDE and its digest right after it. Ops: RX (receive message),
// TX (send digest), HASH (run core) and RX_HASH_TX (all three in order).
//
// Optional feature: define XFER_TIMEOUT_EN to add a per-state stall watchdog
// (TIMEOUT_CYCLES) that ends the command with ERR_TIMEOUT.
//
// State table:
//   IDLE        | waiting for a command, cmd_ready high
//   U_WAIT_IDLE | waiting for uart_manager to be idle
//   U_START     | uart_enable pulse, addresses/mode presented
//   U_WAIT_BUSY | waiting for uart_manager to report busy
//   U_WAIT_DONE | waiting for uart_manager to drop busy
//   C_START     | core_start pulse
//   C_WAIT      | waiting for core_done
//   DONE        | done pulse, status updated
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_slot command fields
//   uart_enable/uart_mode uart_manager start pulse and direction (1 = send)
//   addr_from/addr_to     inclusive RAM byte range for uart_manager
//   uart_busy             uart_manager busy
//   core_start/core_slot  MD5 core start pulse and slot
//   core_done             MD5 core completion pulse
//   done/status           completion pulse and held completion status
//   busy                  sequencer not idle
// ---------------------------------------------------------------------------
module uart_xfer_sequencer
  import md5_xfer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_SLOTS      = 2,
  parameter int SLOT_STRIDE    = 128,
  parameter int MSG_BYTES      = MSG_BYTES_DEF,
  parameter int DIGEST_BYTES   = DIGEST_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(NUM_SLOTS):0]   cmd_slot,
  output logic                         uart_enable,
  output logic                         uart_mode,
  output logic [ADDR_WIDTH-1:0]        addr_from,
  output logic [ADDR_WIDTH-1:0]        addr_to,
  input  logic                         uart_busy,
  output logic                         core_start,
  output logic [$clog2(NUM_SLOTS)-1:0] core_slot,
  input  logic                         core_done,
  output logic                         done,
  output logic [1:0]                   status,
  output logic                         busy
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int SW1    = SLOT_W + 1;
  localparam int AW1    = ADDR_WIDTH + 1;

  // Elaboration-time sanity of the slot map.
  if (NUM_SLOTS < 2) begin : g_chk_slots
    $error("uart_xfer_sequencer: NUM_SLOTS must be at least 2");
  end
  if (NUM_SLOTS * SLOT_STRIDE > (1 << ADDR_WIDTH)) begin : g_chk_map
    $error("uart_xfer_sequencer: slots do not fit the address space");
  end
  if (MSG_BYTES + DIGEST_BYTES > SLOT_STRIDE) begin : g_chk_stride
    $error("uart_xfer_sequencer: message plus digest exceeds slot stride");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_tmo
    $error("uart_xfer_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  state_e              state_q;
  op_e                 op_q;
  logic                tx_phase_q;   // current uart phase sends the digest
  logic [SLOT_W-1:0]   core_slot_q;
  logic                cmd_ready_q;
  logic                uart_enable_q;
  logic                uart_mode_q;
  logic [ADDR_WIDTH-1:0] addr_from_q;
  logic [ADDR_WIDTH-1:0] addr_to_q;
  logic                core_start_q;
  logic                done_q;
  status_e             status_q;
  logic                busy_q;

  logic                tmo_expired;

  // Address range for the pending uart phase, one bit wider than the RAM
  // address so the elaboration checks above guarantee no wrap.
  logic [AW1-1:0] base_w;
  logic [AW1-1:0] from_w;
  logic [AW1-1:0] to_w;
  logic           unused_addr_msb;

  always_comb begin
    base_w = AW1'(core_slot_q) * AW1'(SLOT_STRIDE);
    if (tx_phase_q) begin
      from_w = base_w + AW1'(MSG_BYTES);
      to_w   = from_w + AW1'(DIGEST_BYTES - 1);
    end else begin
      from_w = base_w;
      to_w   = base_w + AW1'(MSG_BYTES - 1);
    end
  end

  assign unused_addr_msb = from_w[ADDR_WIDTH] ^ to_w[ADDR_WIDTH];

`ifdef XFER_TIMEOUT_EN
  state_e prev_state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_state_q <= IDLE;
    end else begin
      prev_state_q <= state_q;
    end
  end

  xfer_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (state_q != prev_state_q),
    .en_i      (is_wait_state(state_q)),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= OP_RX;
      tx_phase_q    <= 1'b0;
      core_slot_q   <= '0;
      cmd_ready_q   <= 1'b1;
      uart_enable_q <= 1'b0;
      uart_mode_q   <= 1'b0;
      addr_from_q   <= '0;
      addr_to_q     <= '0;
      core_start_q  <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= ST_OK;
      busy_q        <= 1'b0;
    end else begin
      uart_enable_q <= 1'b0;
      core_start_q  <= 1'b0;
      done_q        <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            op_q        <= op_e'(cmd_op);
            if (cmd_slot >= SW1'(NUM_SLOTS)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_ERR_SLOT;
            end else begin
              core_slot_q <= cmd_slot[SLOT_W-1:0];
              case (op_e'(cmd_op))
                OP_HASH: begin
                  state_q      <= C_START;
                  core_start_q <= 1'b1;
                end
                OP_TX: begin
                  state_q    <= U_WAIT_IDLE;
                  tx_phase_q <= 1'b1;
                end
                default: begin
                  state_q    <= U_WAIT_IDLE;
                  tx_phase_q <= 1'b0;
                end
              endcase
            end
          end
        end

        U_WAIT_IDLE: begin
          if (tmo_expired) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            status_q <= ST_ERR_TIMEOUT;
          end else if (!uart_busy) begin
            state_q       <= U_START;
            uart_enable_q <= 1'b1;
            uart_mode_q   <= tx_phase_q;
            addr_from_q   <= from_w[ADDR_WIDTH-1:0];
            addr_to_q     <= to_w[ADDR_WIDTH-1:0];
          end
        end

        U_START: begin
          state_q <= U_WAIT_BUSY;
        end

        U_WAIT_BUSY: begin
          if (tmo_expired) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            status_q <= ST_ERR_TIMEOUT;
          end else if (uart_busy) begin
            state_q <= U_WAIT_DONE;
          end
        end

        U_WAIT_DONE: begin
          if (tmo_expired) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            status_q <= ST_ERR_TIMEOUT;
          end else if (!uart_busy) begin
            if (!tx_phase_q && (op_q == OP_RX_HASH_TX)) begin
              state_q      <= C_START;
              core_start_q <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_OK;
            end
          end
        end

        C_START: begin
          state_q <= C_WAIT;
        end

        C_WAIT: begin
          if (tmo_expired) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            status_q <= ST_ERR_TIMEOUT;
          end else if (core_done) begin
            if (op_q == OP_RX_HASH_TX) begin
              state_q    <= U_WAIT_IDLE;
              tx_phase_q <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_OK;
            end
          end
        end

        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign uart_enable = uart_enable_q;
  assign uart_mode   = uart_mode_q;
  assign addr_from   = addr_from_q;
  assign addr_to     = addr_to_q;
  assign core_start  = core_start_q;
  assign core_slot   = core_slot_q;
  assign done        = done_q;
  assign status      = status_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_xfer_sequencer.sv
module tb_uart_xfer_sequencer;

`ifdef XFER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 50000000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_slot = 2'd0;
  logic       uart_enable;
  logic       uart_mode;
  logic [7:0] addr_from;
  logic [7:0] addr_to;
  logic       uart_busy;
  logic       core_start;
  logic [0:0] core_slot;
  logic       core_done;
  logic       done;
  logic [1:0] status;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_xfer_sequencer #(
    .ADDR_WIDTH     (8),
    .NUM_SLOTS      (2),
    .SLOT_STRIDE    (128),
    .MSG_BYTES      (64),
    .DIGEST_BYTES   (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_slot    (cmd_slot),
    .uart_enable (uart_enable),
    .uart_mode   (uart_mode),
    .addr_from   (addr_from),
    .addr_to     (addr_to),
    .uart_busy   (uart_busy),
    .core_start  (core_start),
    .core_slot   (core_slot),
    .core_done   (core_done),
    .done        (done),
    .status      (status),
    .busy        (busy)
  );

  // ---------------- environment models ----------------
  // uart_manager: busy high for 10 cycles starting 2 cycles after enable.
  // core: core_done pulses core_lat cycles after core_start (0 = never).
  int   cyc = 0;
  int   en_cyc = -1000;
  int   cs_cyc = -1000;
  int   core_lat = 20;
  logic busy_hold = 1'b0;
  logic stray_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  assign uart_busy = busy_hold || ((cyc >= en_cyc + 2) && (cyc < en_cyc + 12));
  assign core_done = stray_done || ((core_lat > 0) && (cyc == cs_cyc + core_lat));

  typedef struct packed {
    logic       mode;
    logic [7:0] from;
    logic [7:0] to;
  } xfer_t;

  xfer_t uart_q[$];
  int    core_q[$];
  int    acc_q[$];
  int    done_cyc_q[$];
  int    status_q[$];
  int    ready_bad = 0;
  int    busy_bad = 0;
  logic  in_flight = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      in_flight <= 1'b0;
    end else begin
      if (uart_enable) begin
        en_cyc <= cyc;
        uart_q.push_back({uart_mode, addr_from, addr_to});
      end
      if (core_start) begin
        cs_cyc <= cyc;
        core_q.push_back(int'(core_slot));
      end
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc);
        in_flight <= 1'b1;
      end
      if (in_flight) begin
        if (cmd_ready) ready_bad++;
        if (!busy) busy_bad++;
      end
      if (done) begin
        done_cyc_q.push_back(cyc);
        status_q.push_back(int'(status));
        in_flight <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":outputs"},
          {7'd0, cmd_ready, uart_enable, uart_mode, addr_from, addr_to,
           core_start, core_slot, done, status, busy},
          32'h0100_0000);
  endtask

  // Caller is at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int op, input int slot, input string tag);
    int k;
    for (k = 0; k < 50; k++) begin
      if (cmd_ready === 1'b1) break;
      @(negedge clk);
    end
    check({tag, ":ready_before_issue"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_slot  = 2'(slot);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Reference model: per-op phase list built from the slot map, with
  // per-phase latencies (uart phase 14 cycles, core phase core_lat+1).
  task automatic run_cmd(input int op, input int slot, input int lat,
                         input int settle, input string tag);
    xfer_t exp_x[$];
    int    exp_core[$];
    int    exp_stat;
    int    exp_lat;
    int    base;
    int    n_u0, n_c0, n_a0, n_d0, rb0, bb0;
    logic  got;
    xfer_t obs_x;
    int    obs_c;

    core_lat = lat;
    base     = slot * 128;
    exp_lat  = 1;
    if (slot >= 2) begin
      exp_stat = 1;
    end else begin
      exp_stat = 0;
      if (op == 0 || op == 2) begin
        exp_x.push_back({1'b0, 8'(base), 8'(base + 63)});
        exp_lat += 14;
      end
      if (op == 3 || op == 2) begin
        exp_core.push_back(slot);
        exp_lat += lat + 1;
      end
      if (op == 1 || op == 2) begin
        exp_x.push_back({1'b1, 8'(base + 64), 8'(base + 79)});
        exp_lat += 14;
      end
    end

    n_u0 = uart_q.size();
    n_c0 = core_q.size();
    n_a0 = acc_q.size();
    n_d0 = done_cyc_q.size();
    rb0  = ready_bad;
    bb0  = busy_bad;

    issue(op, slot, tag);

    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_cyc_q.size() > n_d0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, ":done_seen"}, got, 1);
    repeat (settle) @(negedge clk);

    check({tag, ":accept_count"}, acc_q.size() - n_a0, 1);
    check({tag, ":done_count"}, done_cyc_q.size() - n_d0, 1);
    if (got && acc_q.size() > n_a0) begin
      check({tag, ":status"}, status_q[n_d0], exp_stat);
      check({tag, ":latency"}, done_cyc_q[n_d0] - acc_q[n_a0], exp_lat);
    end
    check({tag, ":held_status"}, status, exp_stat);
    check({tag, ":uart_enables"}, uart_q.size() - n_u0, exp_x.size());
    foreach (exp_x[i]) begin
      obs_x = (n_u0 + i < uart_q.size()) ? uart_q[n_u0 + i] : 'x;
      check($sformatf("%s:xfer%0d", tag, i), 32'(obs_x), 32'(exp_x[i]));
    end
    check({tag, ":core_starts"}, core_q.size() - n_c0, exp_core.size());
    foreach (exp_core[i]) begin
      obs_c = (n_c0 + i < core_q.size()) ? core_q[n_c0 + i] : -1;
      check($sformatf("%s:core_slot%0d", tag, i), obs_c, exp_core[i]);
    end
    check({tag, ":ready_low_inflight"}, ready_bad - rb0, 0);
    check({tag, ":busy_high_inflight"}, busy_bad - bb0, 0);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int n_u0, n_c0, n_d0, rel, a0, k;
    logic got;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("post_reset_idle");

    run_cmd(0, 1, 20, 2, "rx_s1");
    run_cmd(1, 0, 20, 2, "tx_s0");
    run_cmd(2, 0, 20, 2, "rhtx_s0");
    run_cmd(0, 2, 20, 2, "bad_slot2");
    run_cmd(3, 3, 20, 2, "bad_slot3");
    run_cmd(3, 1, 5, 2, "hash_s1");
    run_cmd(2, 1, 1, 2, "rhtx_s1_fastcore");

    // core_done while idle must be ignored
    n_c0 = core_q.size();
    n_d0 = done_cyc_q.size();
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_core_done:no_done", done_cyc_q.size() - n_d0, 0);
    check("stray_core_done:idle", {busy, cmd_ready}, 2'b01);

    // next command accepted the cycle right after DONE
    run_cmd(0, 0, 20, 0, "b2b_first");
    a0 = done_cyc_q[done_cyc_q.size() - 1];
    run_cmd(1, 1, 20, 2, "b2b_second");
    check("b2b:accept_after_done", acc_q[acc_q.size() - 1] - a0, 1);

    for (int i = 0; i < 12; i++) begin
      run_cmd(int'($urandom_range(3)), int'($urandom_range(3)),
              int'($urandom_range(30, 1)), 1, $sformatf("rnd%0d", i));
      repeat ($urandom_range(3)) @(negedge clk);
    end

`ifdef XFER_TIMEOUT_EN
    // core never answers: done 100 cycles after C_WAIT entry (accept + 2)
    core_lat = 0;
    n_d0 = done_cyc_q.size();
    issue(3, 0, "timeout");
    a0 = acc_q[acc_q.size() - 1];
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_cyc_q.size() > n_d0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("timeout:done_seen", got, 1);
    if (got) begin
      check("timeout:latency", done_cyc_q[n_d0] - a0, 102);
      check("timeout:status", status_q[n_d0], 2);
    end
    repeat (2) @(negedge clk);
    core_lat = 20;
`endif

    // uart busy already high at accept, then reset during U_WAIT_DONE
    n_u0 = uart_q.size();
    n_d0 = done_cyc_q.size();
    busy_hold = 1'b1;
    issue(1, 1, "preheld");
    repeat (5) @(negedge clk);
    check("preheld:no_enable_while_busy", uart_q.size() - n_u0, 0);
    check("preheld:still_busy", busy, 1);
    busy_hold = 1'b0;
    rel = cyc;
    got = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (uart_q.size() > n_u0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("preheld:enable_seen", got, 1);
    check("preheld:enable_cycle", en_cyc - rel, 1);
    if (got) check("preheld:xfer", 32'(uart_q[n_u0]), 32'({1'b1, 8'hC0, 8'hCF}));
    for (k = 0; k < 20; k++) begin
      if (uart_busy === 1'b1) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    @(negedge clk);
    check_reset_vals("midop_reset_held");
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset:no_done", done_cyc_q.size() - n_d0, 0);
    check("midop_reset:ready", cmd_ready, 1);
    repeat (15) @(negedge clk);
    run_cmd(0, 1, 20, 2, "after_reset_rx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

endmodule
